// File: rtl/cascade_boxcar_filter.sv
// -----------------------------------------------------------------------------
// cascade_boxcar_filter
//
// Cascade of signed boxcar (moving-average) stages placed between the lock-in
// mixer output and the PID/lock logic. Each stage keeps a running sum over a
// circular buffer, so a window of 2^L samples costs one add, one subtract and
// one buffer read per sample regardless of L.
//
// Optional build macro: CASCADE_BOXCAR_ROUND_EN
//   undefined : enabled stages output floor(sum / 2^L) (arithmetic shift)
//   defined   : enabled stages with L>0 output (sum + 2^(L-1)) >>> L, i.e.
//               round half toward +inf, saturating at the max positive value
//   Latency is identical in both builds.
//
// Ports (top):
//   clk              clock
//   rst              synchronous active-high reset
//   stage_enable     [num_stages]        1: stage filters, 0: registered pass
//   stage_log2_len   [num_stages*log2_w] field i = window log2 of stage i,
//                                        clamped to max_log2_len
//   sample_in        [data_width]        signed input sample
//   sample_in_valid                      strobe qualifying sample_in
//   sample_out       [data_width]        signed filtered sample (holds)
//   sample_out_valid                     strobe, exactly num_stages cycles
//                                        after sample_in_valid
//   stage_flush      [num_stages]        bit i high for the cycle stage i
//                                        clears on a configuration change
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// cascade_boxcar_stage
//
// One boxcar stage: running sum, circular buffer with per-entry live bits,
// configuration shadow and a one-cycle registered output.
//
// Ports:
//   clk, rst     clock / synchronous active-high reset
//   enable       1: filter, 0: registered pass-through (history frozen)
//   log2_len     requested window log2 (clamped to max_log2_len)
//   din          signed input sample
//   din_valid    strobe qualifying din
//   dout         registered result, holds between valids
//   dout_valid   din_valid delayed one cycle
//   flush        high in the cycle the live config differs from the shadow
// -----------------------------------------------------------------------------
module cascade_boxcar_stage #(
   parameter int data_width   = 16,
   parameter int max_log2_len = 6,
   parameter int log2_w       = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         enable,
   input  logic [log2_w-1:0]            log2_len,
   input  logic signed [data_width-1:0] din,
   input  logic                         din_valid,
   output logic signed [data_width-1:0] dout,
   output logic                         dout_valid,
   output logic                         flush
);

   localparam int depth = 1 << max_log2_len;
   localparam int sum_w = data_width + max_log2_len;
   localparam int ptr_w = max_log2_len;

   // history buffer; entries are only meaningful while their live bit is set,
   // which is what lets a flush empty the history in a single cycle
   logic signed [data_width-1:0] mem [depth];
   logic [depth-1:0]             live;
   logic [depth-1:0]             live_next;
   logic [ptr_w-1:0]             wp;
   logic [ptr_w-1:0]             rp;
   logic signed [data_width-1:0] mem_rd;

   logic signed [sum_w-1:0]      sum;
   logic signed [sum_w-1:0]      sum_base;
   logic signed [sum_w-1:0]      sum_next;
   logic signed [sum_w-1:0]      sum_upd;
   logic signed [sum_w-1:0]      din_ext;
   logic signed [sum_w-1:0]      old;
   logic signed [data_width-1:0] filt;

   logic [log2_w-1:0]            l_eff;
   logic                         shadow_vld;
   logic                         shadow_en;
   logic [log2_w-1:0]            shadow_len;
   logic                         take;

   assign l_eff = (log2_len > log2_w'(max_log2_len)) ? log2_w'(max_log2_len)
                                                     : log2_len;

   // The shadow is not trusted until one cycle after reset: reset already
   // emptied the history, so capturing the live config then needs no pulse.
   assign flush = shadow_vld &&
                  ((shadow_en != enable) || (shadow_len != log2_len));

   assign take = din_valid && enable;

   // Oldest sample leaving the window sits 2^L entries behind the write
   // pointer. At L = max_log2_len the shift overflows to 0, so rp == wp and the
   // entry about to be overwritten is the one dropped.
   assign rp      = wp - (ptr_w'(1) << l_eff);
   assign mem_rd  = mem[rp];
   assign din_ext = {{max_log2_len{din[data_width-1]}}, din};

   always_comb begin
      old       = '0;
      sum_base  = sum;
      live_next = live;
      sum_upd   = sum;
      if (flush) begin
         sum_base  = '0;
         live_next = '0;
      end
      if (!flush && live[rp])
         old = {{max_log2_len{mem_rd[data_width-1]}}, mem_rd};
      sum_next = sum_base + din_ext - old;
      if (flush)
         sum_upd = '0;
      if (take) begin
         sum_upd       = sum_next;
         live_next[wp] = 1'b1;
      end
   end

`ifdef CASCADE_BOXCAR_ROUND_EN
   // one extra bit so the +2^(L-1) bias can never wrap
   logic signed [sum_w:0] rnd_sum;
   logic signed [sum_w:0] rnd_bias;
   logic signed [sum_w:0] rnd_shr;
   localparam logic signed [sum_w:0] max_pos =
      {{(max_log2_len + 2){1'b0}}, {(data_width - 1){1'b1}}};

   always_comb begin
      rnd_bias = '0;
      if (l_eff != '0)
         rnd_bias = (sum_w + 1)'(1) << (l_eff - log2_w'(1));
      rnd_sum = {sum_next[sum_w-1], sum_next} + rnd_bias;
      rnd_shr = rnd_sum >>> l_eff;
      if (rnd_shr > max_pos)
         filt = max_pos[data_width-1:0];
      else
         filt = rnd_shr[data_width-1:0];
   end
`else
   // the window holds exactly 2^L samples, so the shifted sum fits data_width
   assign filt = data_width'(sum_next >>> l_eff);
`endif

   // buffer storage carries no reset; live bits decide what is valid
   always_ff @(posedge clk) begin
      if (take)
         mem[wp] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sum        <= '0;
         live       <= '0;
         wp         <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         shadow_vld <= 1'b0;
         shadow_en  <= 1'b0;
         shadow_len <= '0;
      end else begin
         dout_valid <= din_valid;
         shadow_vld <= 1'b1;
         shadow_en  <= enable;
         shadow_len <= log2_len;
         sum        <= sum_upd;
         live       <= live_next;
         if (take)
            wp <= wp + ptr_w'(1);
         if (din_valid)
            dout <= enable ? filt : din;
      end
   end

endmodule

// -----------------------------------------------------------------------------
// cascade_boxcar_filter (top)
// -----------------------------------------------------------------------------
module cascade_boxcar_filter #(
   parameter int num_stages   = 4,
   parameter int data_width   = 16,
   parameter int max_log2_len = 6,
   parameter int log2_w       = 3
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [num_stages-1:0]          stage_enable,
   input  logic [num_stages*log2_w-1:0]   stage_log2_len,
   input  logic signed [data_width-1:0]   sample_in,
   input  logic                           sample_in_valid,
   output logic signed [data_width-1:0]   sample_out,
   output logic                           sample_out_valid,
   output logic [num_stages-1:0]          stage_flush
);

   // entry 0 is the block input, entry i+1 the registered output of stage i
   logic [num_stages:0][data_width-1:0] data_pipe;
   logic [num_stages:0]                 vld_pipe;

   assign data_pipe[0] = sample_in;
   assign vld_pipe[0]  = sample_in_valid;

   for (genvar i = 0; i < num_stages; i++) begin : g_stage
      cascade_boxcar_stage #(
         .data_width   (data_width),
         .max_log2_len (max_log2_len),
         .log2_w       (log2_w)
      ) u_stage (
         .clk        (clk),
         .rst        (rst),
         .enable     (stage_enable[i]),
         .log2_len   (stage_log2_len[i*log2_w +: log2_w]),
         .din        (data_pipe[i]),
         .din_valid  (vld_pipe[i]),
         .dout       (data_pipe[i+1]),
         .dout_valid (vld_pipe[i+1]),
         .flush      (stage_flush[i])
      );
   end

   assign sample_out       = data_pipe[num_stages];
   assign sample_out_valid = vld_pipe[num_stages];

endmodule

// File: tb/tb_cascade_boxcar_filter.sv
// -----------------------------------------------------------------------------
// tb_cascade_boxcar_filter
//
// Directed bench for cascade_boxcar_filter (4 stages, 16-bit, 2^6 windows).
// Stimulus pushes {expected value, expected output cycle} into a queue; an
// independent monitor pops on every sample_out_valid and compares.
// -----------------------------------------------------------------------------
module tb_cascade_boxcar_filter;

   localparam int NS = 4;
   localparam int DW = 16;
   localparam int ML = 6;
   localparam int LW = 3;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic [NS-1:0]          stage_enable;
   logic [NS*LW-1:0]       stage_log2_len;
   logic signed [DW-1:0]   sample_in;
   logic                   sample_in_valid;
   logic signed [DW-1:0]   sample_out;
   logic                   sample_out_valid;
   logic [NS-1:0]          stage_flush;

   typedef struct {
      logic signed [DW-1:0] data;
      int                   cyc;
   } exp_t;

   exp_t q[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   cascade_boxcar_filter #(
      .num_stages   (NS),
      .data_width   (DW),
      .max_log2_len (ML),
      .log2_w       (LW)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .stage_enable     (stage_enable),
      .stage_log2_len   (stage_log2_len),
      .sample_in        (sample_in),
      .sample_in_valid  (sample_in_valid),
      .sample_out       (sample_out),
      .sample_out_valid (sample_out_valid),
      .stage_flush      (stage_flush)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // drive one valid sample; the output is due NS cycles later
   task automatic send(input int x, input int e);
      exp_t ex;
      sample_in       = x[DW-1:0];
      sample_in_valid = 1'b1;
      ex.data = e[DW-1:0];
      ex.cyc  = cyc + NS;
      q.push_back(ex);
      tick();
      sample_in_valid = 1'b0;
   endtask

   // pass through an all-bypass config so every enabled target stage flushes
   task automatic set_cfg(input logic [NS-1:0] en, input logic [NS*LW-1:0] len);
      logic [NS-1:0] fexp;
      stage_enable   = '0;
      stage_log2_len = '0;
      tick();
      stage_enable   = en;
      stage_log2_len = len;
      for (int i = 0; i < NS; i++)
         fexp[i] = en[i] || (len[i*LW +: LW] != '0);
      #1;
      chk("cfg_flush", int'(stage_flush), int'(fexp));
      repeat (2) tick();
   endtask

   task automatic drain();
      repeat (NS + 2) tick();
   endtask

   // plain moving-average reference with zero history
   task automatic run_model(input int n, input int l);
      longint hist[$];
      longint s;
      int     x;
      int     e;
      for (int i = 0; i < n; i++) begin
         if (i < 70)      x = 32767;
         else if (i < 75) x = -32768;
         else             x = int'($urandom_range(0, 65535)) - 32768;
         hist.push_back(longint'(x));
         if (hist.size() > (1 << l))
            void'(hist.pop_front());
         s = 0;
         foreach (hist[k]) s += hist[k];
`ifdef CASCADE_BOXCAR_ROUND_EN
         s = s + (longint'(1) << (l - 1));
         e = int'(s >>> l);
         if (e > 32767) e = 32767;
`else
         e = int'(s >>> l);
`endif
         send(x, e);
      end
   endtask

   // monitor: every output strobe must match the head of the queue
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && sample_out_valid) begin
            if (q.size() == 0) begin
               chk("stray_valid", 1, 0);
            end else begin
               e = q.pop_front();
               chk("sample_out", int'(sample_out), int'(e.data));
               chk("latency", cyc, e.cyc);
            end
         end
      end
   end

   initial begin : stim
      int step_exp[8] = '{25, 50, 75, 100, 100, 100, 100, 100};
      int rst_exp[6]  = '{25, 50, 75, 100, 100, 100};
      int byp[5]      = '{5, -7, 1234, -32768, 32767};
      int ramp[6]     = '{10, 20, 30, 40, 40, 40};
      int imp_exp[6]  = '{4, 16, 24, 16, 4, 0};
      int ndrain;

      sample_in       = '0;
      sample_in_valid = 1'b0;
      stage_enable    = 4'b0001;
      stage_log2_len  = {3'd0, 3'd0, 3'd0, 3'd2};

      // power-on reset
      repeat (3) tick();
      chk("reset_out", int'(sample_out), 0);
      chk("reset_valid", int'(sample_out_valid), 0);
      chk("reset_flush", int'(stage_flush), 0);
      rst = 1'b0;
      tick();
      chk("post_reset_flush", int'(stage_flush), 0);

      // mid-stream reset: 3 reset cycles with valids still asserted
      foreach (rst_exp[i]) send(100, rst_exp[i]);
      rst = 1'b1;
      q.delete();
      sample_in       = 16'sd100;
      sample_in_valid = 1'b1;
      repeat (3) tick();
      chk("midrst_out", int'(sample_out), 0);
      chk("midrst_valid", int'(sample_out_valid), 0);
      chk("midrst_flush", int'(stage_flush), 0);
      rst             = 1'b0;
      sample_in_valid = 1'b0;
      tick();
      chk("midrst_valid_after", int'(sample_out_valid), 0);
      chk("midrst_flush_after", int'(stage_flush), 0);
      drain();

      // step response, stage 0 L=2, back-to-back samples
      foreach (step_exp[i]) send(100, step_exp[i]);
      drain();

      // negative floor, stage 0 L=1
      set_cfg(4'b0001, {3'd0, 3'd0, 3'd0, 3'd1});
`ifdef CASCADE_BOXCAR_ROUND_EN
      send(-3, -1);
      send(-4, -3);
`else
      send(-3, -2);
      send(-4, -4);
`endif
      drain();

      // all bypassed: pure 4-cycle delay
      set_cfg(4'b0000, '0);
      foreach (byp[i]) send(byp[i], byp[i]);
      drain();

      // config change coincident with a valid sample
      set_cfg(4'b0001, {3'd0, 3'd0, 3'd0, 3'd2});
      foreach (ramp[i]) send(40, ramp[i]);
      stage_log2_len = {3'd0, 3'd0, 3'd0, 3'd0};
      #1;
      chk("chg_flush", int'(stage_flush), 1);
      send(8, 8);
      chk("chg_flush_clear", int'(stage_flush), 0);
      send(-9, -9);
      drain();

      // full cascade impulse, L=1 everywhere, valids 5 cycles apart
      set_cfg(4'b1111, {3'd1, 3'd1, 3'd1, 3'd1});
      foreach (imp_exp[i]) begin
         send((i == 0) ? 64 : 0, imp_exp[i]);
         repeat (4) tick();
      end
      drain();

      // longest window across several pointer wraps
      set_cfg(4'b0001, {3'd0, 3'd0, 3'd0, 3'd6});
      run_model(200, 6);
      drain();

      // field 7 clamps to 6
      set_cfg(4'b0001, {3'd0, 3'd0, 3'd0, 3'd7});
      run_model(90, 6);

      ndrain = 0;
      while (q.size() != 0 && ndrain < 50) begin
         tick();
         ndrain++;
      end
      chk("drain_pending", q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cascade_boxcar_filter.md
Name: cascade_boxcar_filter

Overview:
- Successor to the fixed 2-tap low-pass cascade used for lock-in (LIA) demodulation.
- N cascaded signed boxcar (moving-average) stages; each stage has its own runtime window length 2^L (L = 0..max_log2_len) and a bypass enable.
- Each stage uses a running sum over a circular buffer, giving very low cutoff at low logic cost.
- Sits between the LIA mixer output and the PID/lock logic.

Parameters:
- num_stages, 4, number of cascaded stages (>=1).
- data_width, word_width, sample width; signed two's complement.
- max_log2_len, 6, maximum log2 window per stage (buffer depth 2^max_log2_len).
- log2_w, 3, width of each per-stage window field; must satisfy 2^log2_w > max_log2_len.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- stage_enable  in  num_stages  bit i=1: stage i filters; 0: stage i passes its input through (still registered).
- stage_log2_len  in  num_stages*log2_w  field i = L for stage i; values above max_log2_len clamp to max_log2_len.
- sample_in  in  data_width  signed input sample.
- sample_in_valid  in  1  one-cycle strobe qualifying sample_in.
- sample_out  out  data_width  signed filtered sample.
- sample_out_valid  out  1  one-cycle strobe qualifying sample_out.
- stage_flush  out  num_stages  bit i pulses for one cycle when stage i clears on a configuration change.

Behaviour:
- Clock/reset: single clock clk. rst is synchronous, active-high. Reset clears all buffers, running sums, write pointers, output registers and configuration shadows. After reset: sample_out=0, sample_out_valid=0, stage_flush=0.
- Stage pipeline:
  - Stage i consumes a sample only on its input valid.
  - It registers its result and asserts its output valid exactly 1 cycle later.
  - Total latency sample_in_valid -> sample_out_valid is fixed at num_stages cycles, independent of enables and windows.
  - Back-to-back valids, one per cycle, are supported with no stalls.
- Enabled stage, on input valid x, with L = effective window:
  - sum_next = sum + x - buf[wp - 2^L] (mod buffer depth).
  - buf[wp] = x; wp increments, wrapping at 2^max_log2_len.
  - out = sum_next >>> L (arithmetic shift, floor).
  - Sum width is data_width + max_log2_len, so it never overflows. out always fits in data_width.
  - L = 0: out = x.
  - Cleared buffer entries read as 0, so the first 2^L - 1 outputs after a clear ramp from zero (implicit zero history).
- Bypassed stage:
  - out = input, 1-cycle registered.
  - Buffer/sum are not updated while bypassed.
- Configuration shadow (per stage):
  - Each stage registers its (enable, L) pair.
  - A difference between the live inputs and the shadow on any cycle triggers a flush that same cycle: sum=0, all buffer entries logically 0 (valid-bit clear or pointer-span reset; no multi-cycle wipe), stage_flush[i]=1 for that cycle, shadow updated.
  - If an input valid coincides with the flush, that sample is processed with the new configuration as the first sample into the empty history.
  - Downstream stages are not flushed automatically.
- Reset mid-stream: valids in flight are discarded; no sample_out_valid is produced for them.
- sample_out holds its last value between valids.

Optional Feature:
- Macro CASCADE_BOXCAR_ROUND_EN.
- Defined: enabled stages with L>0 output (sum_next + 2^(L-1)) >>> L (round half toward +inf). The intermediate uses one extra bit; a result exceeding the max positive value saturates to max positive.
- Undefined: floor division by arithmetic shift as above. Latency is identical in both builds.

Test Plan:
- Reset: hold rst 3 cycles mid-stream with valids -> sample_out=0, sample_out_valid=0, stage_flush=0 the cycle after reset; no stray valids.
- Step response: num_stages=4, stage 0 enabled with L=2, others bypassed, constant input 100 every cycle -> outputs after 4-cycle latency are 25, 50, 75, 100, 100...
- Negative floor and wrap: stage 0 L=1, inputs -3, -4 -> outputs -2, -4 (round build: -1, -3). Run 200 samples at L=max_log2_len against a reference model -> exact match across pointer wrap.
- Config change with coincident valid: stage 0 L=2 at steady 40; change L to 0 on a cycle with valid x=8 -> stage_flush[0]=1 that cycle, that sample's output is 8.
- Full cascade: all 4 stages enabled with L=1, a single impulse 64 then zeros -> output sequence 4, 16, 24, 16, 4, 0 (binomial), with sparse valids spaced 5 cycles apart and a fixed 4-cycle latency per sample.
- Clamp and bypass: L field 7 with max_log2_len=6 -> behaves as L=6. All stages bypassed -> output equals input delayed by 4 cycles.
